instr_fetch_unit: RTL and testbench

//  Opcode/operand fetch front end feeding INSTR_DECODER and the sequencer.
//  - Reads the opcode byte and determines instruction length (1-3 bytes).
//  - Reads the operand bytes and presents a complete instruction with a valid/ready handshake.
//  - Byte-serial, single outstanding memory request, no prefetch.

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Byte-serial opcode/operand fetch front end: fetches 1-3 bytes per instruction
// and presents the complete instruction to the decoder with a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [7:0]  MEM_DATA,
    input  logic        MEM_VALID,
    input  logic        PC_LOAD,
    input  logic [15:0] PC_NEW,
    output logic [7:0]  INSTR,
    output logic [7:0]  OPER_LO,
    output logic [7:0]  OPER_HI,
    output logic [1:0]  INSTR_LEN,
    output logic [15:0] INSTR_PC,
    output logic        ILLEGAL,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic [15:0] PC
);

    typedef enum logic [1:0] {FETCH_OP, FETCH_LO, FETCH_HI, PRESENT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [7:0]  r_instr;
    logic [7:0]  r_oper_lo;
    logic [7:0]  r_oper_hi;
    logic [1:0]  r_len;
    logic [15:0] r_instr_pc;
    logic        r_illegal;
    logic        w_fetching;
    logic        w_xfer;
    logic [2:0]  w_dec;

    // Returns {illegal, len}; rules are checked in order, first match wins.
    function automatic logic [2:0] decode_len(input logic [7:0] o);
        logic [3:0] lo;
        lo = o[3:0];
        if (o[1:0] == 2'b11)
            decode_len = {1'b1, 2'd1};
        else if (o == 8'h00 || o == 8'h40 || o == 8'h60 || lo == 4'h8 || lo == 4'hA)
            decode_len = {1'b0, 2'd1};
        else if (o == 8'h20 || lo == 4'hC || lo == 4'hD || lo == 4'hE || (lo == 4'h9 && o[4]))
            decode_len = {1'b0, 2'd3};
        else
            decode_len = {1'b0, 2'd2};
    endfunction

    assign w_fetching = (r_state != PRESENT);
    assign w_xfer     = w_fetching && MEM_VALID;
    assign w_dec      = decode_len(MEM_DATA);

    always_comb begin
        w_next = r_state;
        if (PC_LOAD) begin
            w_next = FETCH_OP;
        end else begin
            case (r_state)
                FETCH_OP: if (w_xfer) w_next = (w_dec[1:0] == 2'd1) ? PRESENT : FETCH_LO;
                FETCH_LO: if (w_xfer) w_next = (r_len == 2'd3) ? FETCH_HI : PRESENT;
                FETCH_HI: if (w_xfer) w_next = PRESENT;
                PRESENT:  if (INSTR_READY) w_next = FETCH_OP;
                default:  w_next = FETCH_OP;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= FETCH_OP;
            r_pc       <= RESET_PC;
            r_instr    <= 8'h00;
            r_oper_lo  <= 8'h00;
            r_oper_hi  <= 8'h00;
            r_len      <= 2'd0;
            r_instr_pc <= 16'h0000;
            r_illegal  <= 1'b0;
        end else if (PC_LOAD) begin
            // A redirect drops any byte arriving this cycle.
            r_state <= w_next;
            r_pc    <= PC_NEW;
        end else begin
            r_state <= w_next;
            if (w_xfer) begin
                r_pc <= r_pc + 16'd1;
                case (r_state)
                    FETCH_OP: begin
                        r_instr    <= MEM_DATA;
                        r_instr_pc <= r_pc;
                        r_len      <= w_dec[1:0];
                        r_illegal  <= w_dec[2];
                        r_oper_lo  <= 8'h00;
                        r_oper_hi  <= 8'h00;
                    end
                    FETCH_LO: r_oper_lo <= MEM_DATA;
                    FETCH_HI: r_oper_hi <= MEM_DATA;
                    default: ;
                endcase
            end
        end
    end

    // Outputs show reset values already during the cycle RST is high.
    assign MEM_RD      = !RST && w_fetching;
    assign PC          = RST ? RESET_PC : r_pc;
    assign MEM_ADDR    = PC;
    assign INSTR_VALID = !RST && (r_state == PRESENT);
    assign INSTR       = RST ? 8'h00 : r_instr;
    assign OPER_LO     = RST ? 8'h00 : r_oper_lo;
    assign OPER_HI     = RST ? 8'h00 : r_oper_hi;
    assign INSTR_LEN   = RST ? 2'd0 : r_len;
    assign INSTR_PC    = RST ? 16'h0000 : r_instr_pc;
    assign ILLEGAL     = !RST && r_illegal;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte memory model of configurable wait states.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] MEM_ADDR;
    logic        MEM_RD;
    logic [7:0]  MEM_DATA;
    logic        MEM_VALID;
    logic        PC_LOAD;
    logic [15:0] PC_NEW;
    logic [7:0]  INSTR;
    logic [7:0]  OPER_LO;
    logic [7:0]  OPER_HI;
    logic [1:0]  INSTR_LEN;
    logic [15:0] INSTR_PC;
    logic        ILLEGAL;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [15:0] PC;

    int total = 0;
    int bad   = 0;
    int wait_n = 0;
    int cnt = 0;
    logic [7:0] mem [0:65535];

    instr_fetch_unit #(.RESET_PC(16'h0200)) dut (
        .CLK(CLK), .RST(RST), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
        .MEM_DATA(MEM_DATA), .MEM_VALID(MEM_VALID), .PC_LOAD(PC_LOAD),
        .PC_NEW(PC_NEW), .INSTR(INSTR), .OPER_LO(OPER_LO), .OPER_HI(OPER_HI),
        .INSTR_LEN(INSTR_LEN), .INSTR_PC(INSTR_PC), .ILLEGAL(ILLEGAL),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .PC(PC)
    );

    always #5 CLK = ~CLK;

    // Memory: a request completes once it has waited wait_n cycles.
    assign MEM_DATA  = mem[MEM_ADDR];
    assign MEM_VALID = MEM_RD && (cnt >= wait_n);
    always @(posedge CLK) begin
        if (RST || !MEM_RD || MEM_VALID || PC_LOAD) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (INSTR_VALID) return;
        end
        total++;
        bad++;
        $error("FAIL %s timeout waiting for INSTR_VALID observed=0 expected=1", tag);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd"},    MEM_RD, 0);
        chk({tag, "_vld"},   INSTR_VALID, 0);
        chk({tag, "_pc"},    PC, 16'h0200);
        chk({tag, "_instr"}, INSTR, 0);
        chk({tag, "_lo"},    OPER_LO, 0);
        chk({tag, "_hi"},    OPER_HI, 0);
        chk({tag, "_len"},   INSTR_LEN, 0);
        chk({tag, "_ipc"},   INSTR_PC, 0);
        chk({tag, "_ill"},   ILLEGAL, 0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        RST = 1'b1; PC_LOAD = 1'b0; PC_NEW = 16'h0000; INSTR_READY = 1'b0;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;

        // Reset and 2-byte fetch from 0-wait memory
        tick();
        chk_reset("rst0");
        RST = 1'b0;
        #1;
        chk("rel_rd", MEM_RD, 1);
        chk("rel_addr", MEM_ADDR, 16'h0200);
        chk("rel_instr", INSTR, 0);
        chk("rel_len", INSTR_LEN, 0);
        tick();
        chk("t1_notyet", INSTR_VALID, 0);
        tick();
        chk("t1_vld", INSTR_VALID, 1);
        chk("t1_instr", INSTR, 8'hA9);
        chk("t1_lo", OPER_LO, 8'h42);
        chk("t1_hi", OPER_HI, 8'h00);
        chk("t1_len", INSTR_LEN, 2);
        chk("t1_ipc", INSTR_PC, 16'h0200);
        chk("t1_pc", PC, 16'h0202);
        chk("t1_ill", ILLEGAL, 0);

        // 3-byte instruction with 2 wait states, consumer stalls
        mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
        wait_n = 2;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        wait_valid("t2");
        chk("t2_len", INSTR_LEN, 3);
        chk("t2_lo", OPER_LO, 8'h34);
        chk("t2_hi", OPER_HI, 8'h12);
        chk("t2_pc", PC, 16'h0203);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_vld", INSTR_VALID, 1);
            chk("t2_hold_rd", MEM_RD, 0);
            chk("t2_hold_instr", INSTR, 8'h4C);
            chk("t2_hold_oper", {OPER_HI, OPER_LO}, 16'h1234);
            chk("t2_hold_pc", PC, 16'h0203);
        end

        // Redirect during a completing handshake, then a stream of instructions
        mem[16'h0300] = 8'hEA; mem[16'h0301] = 8'h0A; mem[16'h0302] = 8'h60;
        mem[16'h0303] = 8'h20; mem[16'h0304] = 8'h11; mem[16'h0305] = 8'h22;
        mem[16'h0306] = 8'h03;
        wait_n = 0;
        INSTR_READY = 1'b1; PC_LOAD = 1'b1; PC_NEW = 16'h0300;
        tick();
        PC_LOAD = 1'b0;
        #1;
        chk("t3_load_pc", PC, 16'h0300);
        chk("t3_load_vld", INSTR_VALID, 0);
        tick();
        chk("t3_a_vld", INSTR_VALID, 1);
        chk("t3_a_instr", INSTR, 8'hEA);
        chk("t3_a_len", INSTR_LEN, 1);
        chk("t3_a_ipc", INSTR_PC, 16'h0300);
        chk("t3_a_lo", OPER_LO, 8'h00);
        wait_valid("t3_b");
        chk("t3_b_instr", INSTR, 8'h0A);
        chk("t3_b_len", INSTR_LEN, 1);
        chk("t3_b_ipc", INSTR_PC, 16'h0301);
        wait_valid("t3_c");
        chk("t3_c_instr", INSTR, 8'h60);
        chk("t3_c_len", INSTR_LEN, 1);
        chk("t3_c_ipc", INSTR_PC, 16'h0302);
        wait_valid("t3_d");
        chk("t3_d_len", INSTR_LEN, 3);
        chk("t3_d_oper", {OPER_HI, OPER_LO}, 16'h2211);
        chk("t3_d_ipc", INSTR_PC, 16'h0303);
        wait_valid("t3_e");
        chk("t3_e_ill", ILLEGAL, 1);
        chk("t3_e_len", INSTR_LEN, 1);
        chk("t3_e_ipc", INSTR_PC, 16'h0306);
        chk("t3_e_oper", {OPER_HI, OPER_LO}, 16'h0000);

        // PC wrap across FFFF
        mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
        PC_LOAD = 1'b1; PC_NEW = 16'hFFFE;
        tick();
        PC_LOAD = 1'b0; INSTR_READY = 1'b0;
        wait_valid("t4");
        chk("t4_instr", INSTR, 8'hAD);
        chk("t4_ill", ILLEGAL, 0);
        chk("t4_len", INSTR_LEN, 3);
        chk("t4_lo", OPER_LO, 8'h00);
        chk("t4_hi", OPER_HI, 8'h80);
        chk("t4_ipc", INSTR_PC, 16'hFFFE);
        chk("t4_pc", PC, 16'h0001);

        // Redirect while an operand byte is being returned
        mem[16'h0001] = 8'hA5; mem[16'h0002] = 8'h77; mem[16'h0400] = 8'hEA;
        INSTR_READY = 1'b1;
        tick();
        INSTR_READY = 1'b0;
        tick();
        chk("t5_lo_addr", MEM_ADDR, 16'h0002);
        chk("t5_lo_valid", MEM_VALID, 1);
        PC_LOAD = 1'b1; PC_NEW = 16'h0400;
        tick();
        PC_LOAD = 1'b0;
        #1;
        chk("t5_addr", MEM_ADDR, 16'h0400);
        chk("t5_vld", INSTR_VALID, 0);
        chk("t5_rd", MEM_RD, 1);
        tick();
        chk("t5_new_vld", INSTR_VALID, 1);
        chk("t5_new_instr", INSTR, 8'hEA);
        chk("t5_new_ipc", INSTR_PC, 16'h0400);
        chk("t5_new_pc", PC, 16'h0401);

        // Reset from PRESENT, then from FETCH_HI
        RST = 1'b1;
        tick();
        chk_reset("t6p");
        RST = 1'b0;
        tick();
        tick();
        chk("t6_hi_addr", MEM_ADDR, 16'h0202);
        chk("t6_hi_vld", INSTR_VALID, 0);
        RST = 1'b1;
        tick();
        chk_reset("t6h");
        RST = 1'b0;
        #1;
        chk("t6_rel_rd", MEM_RD, 1);
        chk("t6_rel_addr", MEM_ADDR, 16'h0200);
        wait_valid("t6_refetch");
        chk("t6_instr", INSTR, 8'h4C);
        chk("t6_ipc", INSTR_PC, 16'h0200);
        chk("t6_oper", {OPER_HI, OPER_LO}, 16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
